// File: rtl/csr_cpuif_initiator.sv
// Initiator side of the CSR cpuif: valid/ready command in, one outstanding
// cpuif request, watchdog-guarded ack wait, valid/ready response out.
module csr_cpuif_initiator #(
    parameter int unsigned AW      = 12,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_addr_i,
    input  logic [DW-1:0]   cmd_wdata_i,
    input  logic [DW/8-1:0] cmd_strb_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_rdata_o,
    output logic            rsp_err_o,
    output logic            rsp_timeout_o,
    output logic            stale_ack_o,
    output logic            m_cpuif_req,
    output logic            m_cpuif_req_is_wr,
    output logic [AW-1:0]   m_cpuif_addr,
    output logic [DW-1:0]   m_cpuif_wr_data,
    output logic [DW-1:0]   m_cpuif_wr_biten,
    input  logic            m_cpuif_req_stall_wr,
    input  logic            m_cpuif_req_stall_rd,
    input  logic            m_cpuif_rd_ack,
    input  logic            m_cpuif_rd_err,
    input  logic [DW-1:0]   m_cpuif_rd_data,
    input  logic            m_cpuif_wr_ack,
    input  logic            m_cpuif_wr_err
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;

    logic          w_stall;
    logic          w_ack;
    logic          w_err;
    logic          w_wrong_ack;
    logic          w_accept;
    logic          w_ack_ok;
    logic          w_stale;
    logic          w_wd_fire;
    logic [DW-1:0] w_biten;

    assign cmd_ready_o = (r_state == S_IDLE);

    // Stall, ack and error are selected by the type of the outstanding command
    assign w_stall     = m_cpuif_req_is_wr ? m_cpuif_req_stall_wr : m_cpuif_req_stall_rd;
    assign w_ack       = m_cpuif_req_is_wr ? m_cpuif_wr_ack : m_cpuif_rd_ack;
    assign w_err       = m_cpuif_req_is_wr ? m_cpuif_wr_err : m_cpuif_rd_err;
    assign w_wrong_ack = m_cpuif_req_is_wr ? m_cpuif_rd_ack : m_cpuif_wr_ack;

    assign w_accept  = (r_state == S_REQ) && !w_stall;
    assign w_ack_ok  = w_ack && (w_accept || (r_state == S_WAIT));
    assign w_stale   = (w_ack && !(w_accept || (r_state == S_WAIT))) || w_wrong_ack;
    assign w_wd_fire = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

    // Expand byte strobes to per-bit write enables
    always_comb begin
        w_biten = '0;
        for (int i = 0; i < int'(SW); i++) begin
            w_biten[8*i +: 8] = {8{cmd_strb_i[i]}};
        end
    end

    // Transaction FSM with registered cpuif and response outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state           <= S_IDLE;
            r_cnt             <= '0;
            rsp_valid_o       <= 1'b0;
            rsp_rdata_o       <= '0;
            rsp_err_o         <= 1'b0;
            rsp_timeout_o     <= 1'b0;
            stale_ack_o       <= 1'b0;
            m_cpuif_req       <= 1'b0;
            m_cpuif_req_is_wr <= 1'b0;
            m_cpuif_addr      <= '0;
            m_cpuif_wr_data   <= '0;
            m_cpuif_wr_biten  <= '0;
        end else begin
            if (w_stale) begin
                stale_ack_o <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        m_cpuif_req       <= 1'b1;
                        m_cpuif_req_is_wr <= cmd_we_i;
                        m_cpuif_addr      <= cmd_addr_i;
                        m_cpuif_wr_data   <= cmd_wdata_i;
                        m_cpuif_wr_biten  <= w_biten;
                        r_cnt             <= '0;
                        r_state           <= S_REQ;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (TIMEOUT != 0) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (w_ack_ok) begin
                        m_cpuif_req   <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= w_err;
                        rsp_timeout_o <= 1'b0;
                        rsp_rdata_o   <= (m_cpuif_req_is_wr || w_err) ? '0 : m_cpuif_rd_data;
                        r_state       <= S_RESP;
                    end else if (w_wd_fire) begin
                        m_cpuif_req   <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                        rsp_rdata_o   <= '0;
                        r_state       <= S_RESP;
                    end else if (w_accept) begin
                        m_cpuif_req <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_cpuif_initiator.sv
// Randomized self-checking bench for csr_cpuif_initiator against a
// transaction-level timing model (stall count, ack delay, watchdog).
module tb_csr_cpuif_initiator;

    localparam int unsigned AW  = 12;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int          TMO = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic            cmd_we_i;
    logic [AW-1:0]   cmd_addr_i;
    logic [DW-1:0]   cmd_wdata_i;
    logic [SW-1:0]   cmd_strb_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [DW-1:0]   rsp_rdata_o;
    logic            rsp_err_o;
    logic            rsp_timeout_o;
    logic            stale_ack_o;
    logic            m_cpuif_req;
    logic            m_cpuif_req_is_wr;
    logic [AW-1:0]   m_cpuif_addr;
    logic [DW-1:0]   m_cpuif_wr_data;
    logic [DW-1:0]   m_cpuif_wr_biten;
    logic            m_cpuif_req_stall_wr;
    logic            m_cpuif_req_stall_rd;
    logic            m_cpuif_rd_ack;
    logic            m_cpuif_rd_err;
    logic [DW-1:0]   m_cpuif_rd_data;
    logic            m_cpuif_wr_ack;
    logic            m_cpuif_wr_err;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic exp_stale;

    csr_cpuif_initiator #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) u_dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .cmd_valid_i          (cmd_valid_i),
        .cmd_ready_o          (cmd_ready_o),
        .cmd_we_i             (cmd_we_i),
        .cmd_addr_i           (cmd_addr_i),
        .cmd_wdata_i          (cmd_wdata_i),
        .cmd_strb_i           (cmd_strb_i),
        .rsp_valid_o          (rsp_valid_o),
        .rsp_ready_i          (rsp_ready_i),
        .rsp_rdata_o          (rsp_rdata_o),
        .rsp_err_o            (rsp_err_o),
        .rsp_timeout_o        (rsp_timeout_o),
        .stale_ack_o          (stale_ack_o),
        .m_cpuif_req          (m_cpuif_req),
        .m_cpuif_req_is_wr    (m_cpuif_req_is_wr),
        .m_cpuif_addr         (m_cpuif_addr),
        .m_cpuif_wr_data      (m_cpuif_wr_data),
        .m_cpuif_wr_biten     (m_cpuif_wr_biten),
        .m_cpuif_req_stall_wr (m_cpuif_req_stall_wr),
        .m_cpuif_req_stall_rd (m_cpuif_req_stall_rd),
        .m_cpuif_rd_ack       (m_cpuif_rd_ack),
        .m_cpuif_rd_err       (m_cpuif_rd_err),
        .m_cpuif_rd_data      (m_cpuif_rd_data),
        .m_cpuif_wr_ack       (m_cpuif_wr_ack),
        .m_cpuif_wr_err       (m_cpuif_wr_err)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_slave();
        m_cpuif_req_stall_wr = 1'b0;
        m_cpuif_req_stall_rd = 1'b0;
        m_cpuif_rd_ack       = 1'b0;
        m_cpuif_rd_err       = 1'b0;
        m_cpuif_wr_ack       = 1'b0;
        m_cpuif_wr_err       = 1'b0;
        m_cpuif_rd_data      = DW'($urandom);
    endtask

    // One full transaction. s = stalled cycles before acceptance, d = cycles
    // from acceptance to ack, rw = cycles rsp_ready is held low, wrong = inject
    // a wrong-type ack one cycle after acceptance.
    task automatic do_txn(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [SW-1:0] strb,
                          input int s, input int d, input logic err,
                          input logic [DW-1:0] rd, input int rw, input logic wrong);
        int            ackc;
        int            fin;
        logic          to;
        logic [DW-1:0] exp_biten;
        logic [DW-1:0] exp_rdata;
        ackc = s + d;
        to   = (TMO != 0) && (ackc >= TMO);
        fin  = to ? TMO : ackc + 1;
        exp_biten = '0;
        for (int i = 0; i < int'(SW); i++) begin
            if (strb[i]) exp_biten = exp_biten | (DW'(255) << (8 * i));
        end
        exp_rdata = (we || err || to) ? '0 : rd;

        check("cmd_ready_idle", 64'(cmd_ready_o), 64'(1));
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_wdata_i = wd;
        cmd_strb_i  = strb;
        step();
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'($urandom);
        cmd_addr_i  = AW'($urandom);
        cmd_wdata_i = DW'($urandom);
        cmd_strb_i  = SW'($urandom);

        for (int k = 0; k < fin; k++) begin
            check("req", 64'(m_cpuif_req), 64'(k <= s));
            if (k <= s) begin
                check("req_is_wr", 64'(m_cpuif_req_is_wr), 64'(we));
                check("req_addr", 64'(m_cpuif_addr), 64'(addr));
                check("req_wdata", 64'(m_cpuif_wr_data), 64'(wd));
                check("req_biten", 64'(m_cpuif_wr_biten), 64'(exp_biten));
            end
            check("rsp_valid_busy", 64'(rsp_valid_o), 64'(0));
            check("cmd_ready_busy", 64'(cmd_ready_o), 64'(0));
            if (we) begin
                m_cpuif_req_stall_wr = (k < s);
                m_cpuif_req_stall_rd = 1'($urandom);
            end else begin
                m_cpuif_req_stall_rd = (k < s);
                m_cpuif_req_stall_wr = 1'($urandom);
            end
            if (k == ackc) begin
                if (we) begin
                    m_cpuif_wr_ack = 1'b1;
                    m_cpuif_wr_err = err;
                end else begin
                    m_cpuif_rd_ack  = 1'b1;
                    m_cpuif_rd_err  = err;
                    m_cpuif_rd_data = rd;
                end
            end else if (wrong && k == s + 1) begin
                if (we) m_cpuif_rd_ack = 1'b1;
                else    m_cpuif_wr_ack = 1'b1;
                exp_stale = 1'b1;
            end
            step();
            clear_slave();
        end

        for (int h = 0; h <= rw; h++) begin
            check("rsp_valid", 64'(rsp_valid_o), 64'(1));
            check("rsp_rdata", 64'(rsp_rdata_o), 64'(exp_rdata));
            check("rsp_err", 64'(rsp_err_o), 64'(to | err));
            check("rsp_timeout", 64'(rsp_timeout_o), 64'(to));
            check("cmd_ready_resp", 64'(cmd_ready_o), 64'(0));
            check("req_resp", 64'(m_cpuif_req), 64'(0));
            rsp_ready_i = (h == rw);
            step();
        end
        rsp_ready_i = 1'b0;
        check("rsp_valid_done", 64'(rsp_valid_o), 64'(0));
        check("cmd_ready_done", 64'(cmd_ready_o), 64'(1));
        check("stale_ack", 64'(stale_ack_o), 64'(exp_stale));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_addr_i  = '0;
        cmd_wdata_i = '0;
        cmd_strb_i  = '0;
        rsp_ready_i = 1'b0;
        exp_stale   = 1'b0;
        clear_slave();
        step();
        step();
        check("rst_req", 64'(m_cpuif_req), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'(1));
        check("rst_stale", 64'(stale_ack_o), 64'(0));
        check("rst_rsp_err", 64'(rsp_err_o), 64'(0));
        check("rst_biten", 64'(m_cpuif_wr_biten), 64'(0));
        rst_i = 1'b0;
        step();

        // Zero-wait read
        do_txn(1'b0, 12'h024, 32'h0, 4'hF, 0, 0, 1'b0, 32'hDEADBEEF, 0, 1'b0);
        // Write with partial strobes
        do_txn(1'b1, 12'h010, 32'h11223344, 4'b0101, 0, 1, 1'b0, 32'hCAFE0000, 0, 1'b0);
        // Write stalled for 3 cycles
        do_txn(1'b1, 12'h200, 32'hA5A5_0F0F, 4'b1110, 3, 1, 1'b0, 32'h0, 0, 1'b0);
        // Read error with delayed response consumption
        do_txn(1'b0, 12'h0FC, 32'h0, 4'h0, 0, 2, 1'b1, 32'h12345678, 5, 1'b0);
        // Watchdog expiry, then a late read ack
        do_txn(1'b0, 12'h300, 32'h0, 4'h0, 0, 20, 1'b0, 32'h0, 0, 1'b0);
        m_cpuif_rd_ack = 1'b1;
        step();
        clear_slave();
        exp_stale = 1'b1;
        check("late_ack_stale", 64'(stale_ack_o), 64'(1));
        check("late_ack_idle", 64'(cmd_ready_o), 64'(1));
        // Ack on the last watchdog cycle wins over the timeout
        do_txn(1'b0, 12'h304, 32'h0, 4'h0, 2, TMO - 3, 1'b0, 32'h0BADF00D, 1, 1'b0);

        // Reset while waiting for an ack
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_addr_i  = 12'h0AA;
        step();
        cmd_valid_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
        step();
        check("rstwait_req", 64'(m_cpuif_req), 64'(0));
        check("rstwait_rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("rstwait_cmd_ready", 64'(cmd_ready_o), 64'(1));
        check("rstwait_stale", 64'(stale_ack_o), 64'(0));
        rst_i     = 1'b0;
        exp_stale = 1'b0;
        step();

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            do_txn(1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                   ($urandom_range(0, 3) == 0), DW'($urandom),
                   int'($urandom_range(0, 3)), 1'b0);
        end

        // Wrong-type ack during the wait is ignored but flagged
        do_txn(1'b1, 12'h044, 32'h55AA55AA, 4'hF, 1, 3, 1'b0, 32'h0, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
